// File: rtl/fall_detect_ctrl.sv
// Fall-event sequencer driven by the squared-magnitude sample stream.
// Walks free-fall -> impact -> stillness, counting in samples (not clocks).
// A confirmed fall latches fall_alarm until acknowledged and bumps a
// saturating event counter.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     detector enable; low forces IDLE and drops the alarm
//   mag_valid  single-cycle strobe qualifying mag_sq
//   mag_sq     unsigned ax^2+ay^2+az^2
//   alarm_ack  single-cycle acknowledge that clears the alarm
//   fall_alarm high while a confirmed fall awaits acknowledge
//   state      current FSM state (IDLE=0 .. ALARM=4)
//   fall_count confirmed falls, saturating at 255
module fall_detect_ctrl #(
  parameter logic [31:0] FF_THRESH      = 32'd2684355,
  parameter int unsigned FF_MIN_SAMPLES = 5,
  parameter logic [31:0] IMPACT_THRESH  = 32'd104857600,
  parameter int unsigned IMPACT_WINDOW  = 50,
  parameter logic [31:0] STILL_LO       = 32'd10737418,
  parameter logic [31:0] STILL_HI       = 32'd24159191,
  parameter int unsigned STILL_SAMPLES  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mag_valid,
  input  logic [31:0] mag_sq,
  input  logic        alarm_ack,
  output logic        fall_alarm,
  output logic [2:0]  state,
  output logic [7:0]  fall_count
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FREEFALL    = 3'd1,
    IMPACT_WAIT = 3'd2,
    STILL_CHECK = 3'd3,
    ALARM       = 3'd4
  } state_t;

  state_t      st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic        alarm_q, alarm_d;
  logic [7:0]  count_q, count_d;

  logic        is_ff, is_impact, is_still;
  logic [31:0] cnt_plus;

  assign is_ff     = mag_sq < FF_THRESH;
  assign is_impact = mag_sq > IMPACT_THRESH;
  assign is_still  = (mag_sq >= STILL_LO) && (mag_sq <= STILL_HI);
  // Widened so the "next count reaches limit" test never wraps at 16 bits.
  assign cnt_plus  = {16'd0, cnt_q} + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    count_d = count_q;

    if (!enable) begin
      st_d    = IDLE;
      cnt_d   = '0;
      alarm_d = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (mag_valid && is_ff) begin
            st_d  = FREEFALL;
            cnt_d = 16'd1;
          end
        end
        FREEFALL: begin
          if (mag_valid) begin
            if (!is_ff) begin
              st_d  = IDLE;
              cnt_d = '0;
            end else if (cnt_plus == FF_MIN_SAMPLES) begin
              st_d  = IMPACT_WAIT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        IMPACT_WAIT: begin
          // Impact is tested first so it wins on the last window sample.
          if (mag_valid) begin
            if (is_impact) begin
              st_d  = STILL_CHECK;
              cnt_d = '0;
            end else if (cnt_plus == IMPACT_WINDOW) begin
              st_d  = IDLE;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        STILL_CHECK: begin
          if (mag_valid) begin
            if (!is_still) begin
              st_d  = IDLE;
              cnt_d = '0;
            end else if (cnt_plus == STILL_SAMPLES) begin
              st_d    = ALARM;
              cnt_d   = '0;
              alarm_d = 1'b1;
              if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ALARM: begin
          // Samples are not evaluated here; one arriving with the ack is dropped.
          if (alarm_ack) begin
            st_d    = IDLE;
            alarm_d = 1'b0;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign fall_alarm = alarm_q;
  assign state      = st_q;
  assign fall_count = count_q;

endmodule

// File: doc/fall_detect_ctrl.md
Name: fall_detect_ctrl

Overview:
Fall-event sequencer that consumes the squared-magnitude stream (mag_sq / mag_valid) from the magnitude datapath. It runs a free-fall -> impact -> stillness state machine, counting in samples. On a confirmed fall it raises a latched alarm and increments a saturating event counter. It sits between the magnitude stage and the alarm/IRQ logic.

Parameters:
FF_THRESH, 2684355, mag_sq strictly below this counts as free-fall (about 0.4 g squared at 4096 LSB/g)
FF_MIN_SAMPLES, 5, consecutive free-fall samples required; legal range 2..65535
IMPACT_THRESH, 104857600, mag_sq strictly above this counts as impact (about 2.5 g squared)
IMPACT_WINDOW, 50, samples allowed after free-fall for an impact to occur; legal range 1..65535
STILL_LO, 10737418, lower bound of the stillness band, inclusive (about 0.8 g squared)
STILL_HI, 24159191, upper bound of the stillness band, inclusive (about 1.2 g squared)
STILL_SAMPLES, 100, consecutive in-band samples required to confirm a fall; legal range 1..65535

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  detector enable; low forces IDLE
mag_valid  in  1  single-cycle strobe; mag_sq is valid while it is high
mag_sq  in  32  unsigned ax²+ay²+az²
alarm_ack  in  1  single-cycle acknowledge that clears the alarm
fall_alarm  out  1  high while a confirmed fall is pending acknowledge
state  out  3  current FSM state, encoded as below
fall_count  out  8  number of confirmed falls, saturates at 255

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sample counter=0, fall_alarm=0, fall_count=0. All outputs are registered.
- State encoding: IDLE=0, FREEFALL=1, IMPACT_WAIT=2, STILL_CHECK=3, ALARM=4.
- Internal sample counter is 16 bits. It changes only on cycles with mag_valid=1 and enable=1, except for clears.
- All comparisons are unsigned 32-bit.
- Timing: the state change takes effect on the same edge at which the qualifying sample is captured. fall_alarm rises the cycle after the final still sample is presented.
- IDLE:
  - mag_sq < FF_THRESH -> FREEFALL, cnt=1.
  - Any other sample -> stay in IDLE.
- FREEFALL:
  - mag_sq < FF_THRESH: if cnt+1 == FF_MIN_SAMPLES -> IMPACT_WAIT, cnt=0; otherwise cnt++.
  - mag_sq >= FF_THRESH -> IDLE, cnt=0.
- IMPACT_WAIT (every sample is evaluated):
  - mag_sq > IMPACT_THRESH -> STILL_CHECK, cnt=0.
  - Otherwise, if cnt+1 == IMPACT_WINDOW -> IDLE (timeout); else cnt++.
  - If the impact arrives on the final window sample, impact wins.
- STILL_CHECK:
  - STILL_LO <= mag_sq <= STILL_HI: if cnt+1 == STILL_SAMPLES -> ALARM, fall_alarm<=1, fall_count<=sat(fall_count+1), cnt=0; otherwise cnt++.
  - Out-of-band sample -> IDLE, cnt=0.
- ALARM:
  - fall_alarm is held high; mag_valid is ignored.
  - alarm_ack=1 -> IDLE, fall_alarm<=0 on that edge.
  - If alarm_ack and mag_valid arrive together, the sample is dropped and is not evaluated in IDLE.
- alarm_ack in any state other than ALARM is ignored.
- enable=0 (synchronous, any state): next state=IDLE, cnt=0, fall_alarm=0; fall_count is retained. Samples are ignored while enable=0. enable=0 takes priority over alarm_ack and mag_valid.
- fall_count at 255 stays at 255 on further falls; only reset clears it.
- mag_valid low cycles between samples have no effect; no timeout is measured in clock cycles.
- Reset asserted mid-sequence returns everything to reset values immediately; no partial state survives.

Test Plan:
- Nominal fall:
  - Stimulus: 5 samples at 1,000,000; then 3 samples at 16,777,216; then 1 sample at 150,000,000; then 100 samples at 16,777,216.
  - Response: state walks 0->1->2->3->4; fall_alarm=1 one cycle after the 100th still sample; fall_count=1.
  - Then alarm_ack -> state=0 and fall_alarm=0 on the next cycle.
- Short free-fall:
  - Stimulus: 4 samples at 1,000,000; then 1 sample at 16,777,216.
  - Response: state=1 then back to 0; no alarm; fall_count=0.
- Impact timeout:
  - Stimulus: valid free-fall; then 50 samples at 50,000,000.
  - Response: state returns to 0 on the 50th sample; no alarm.
  - Variant: impact 150,000,000 exactly on the 50th sample -> state=3.
- Stillness broken:
  - Stimulus: free-fall, impact, then 60 in-band samples and 1 sample at 30,000,000.
  - Response: state=0; no alarm.
  - Boundary: samples exactly at STILL_LO and STILL_HI count as in-band.
- Enable and ack corners:
  - enable=0 during STILL_CHECK -> state=0 next cycle.
  - enable=0 in ALARM -> fall_alarm=0; fall_count unchanged.
  - alarm_ack together with mag_valid=1 at 1,000,000 in ALARM -> state=0, not 1.
  - alarm_ack pulsed in IDLE -> no effect.
- Saturation and reset:
  - Drive 256 complete falls, each acknowledged -> fall_count=255.
  - rst_n pulse mid-IMPACT_WAIT -> all outputs 0 asynchronously.
